// File: rtl/io_check_pkg.sv
// Shared types and helpers for the I/O loopback checker.
// Holds the FSM state encoding, default bus/counter widths and a saturating increment.
package io_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 54;
  localparam int DEF_CNT_W = 16;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= top) ? top : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no bus coherency is implied.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_loopback_checker.sv
// Board bring-up checker: compares looped-back pins against the toggle-stage outputs
// after a settle window and keeps sticky per-bit error masks plus saturating counters.
//
// state  | meaning
// IDLE   | checking disabled, settle counter held at zero
// SETTLE | waiting for exp to stay unchanged long enough to cover pin + sync latency
// CHECK  | comparing synchronized pins against exp_q every stable cycle
module io_loopback_checker
  import io_check_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] exp_1,
  input  logic [WIDTH-1:0] exp_2,
  input  logic [WIDTH-1:0] lb_1,
  input  logic [WIDTH-1:0] lb_2,
  output logic [WIDTH-1:0] err_mask_1,
  output logic [WIDTH-1:0] err_mask_2,
  output logic             err_any,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] phase_count,
  output logic             led_ok,
  output logic             led_err
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  // The counter reaches SETTLE_CYCLES-1 on the same edge that enters CHECK.
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 2);

  logic [WIDTH-1:0] sync_lb_1;
  logic [WIDTH-1:0] sync_lb_2;
  logic [WIDTH-1:0] exp_q_1;
  logic [WIDTH-1:0] exp_q_2;
  logic [WIDTH-1:0] diff_1;
  logic [WIDTH-1:0] diff_2;
  logic             chg;
  logic             mismatch;
  logic             compare;
  logic             phase_done;

  state_t           state;
  state_t           state_next;
  logic [SC_W-1:0]  settle_cnt;
  logic [SC_W-1:0]  settle_cnt_next;

  sync2 #(.W(WIDTH)) u_sync_1 (
    .clk (clk),
    .rst (rst),
    .d   (lb_1),
    .q   (sync_lb_1)
  );

  sync2 #(.W(WIDTH)) u_sync_2 (
    .clk (clk),
    .rst (rst),
    .d   (lb_2),
    .q   (sync_lb_2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_1 <= '0;
      exp_q_2 <= '0;
    end else begin
      exp_q_1 <= exp_1;
      exp_q_2 <= exp_2;
    end
  end

  assign chg      = (exp_1 != exp_q_1) || (exp_2 != exp_q_2);
  assign diff_1   = sync_lb_1 ^ exp_q_1;
  assign diff_2   = sync_lb_2 ^ exp_q_2;
  assign mismatch = (|diff_1) || (|diff_2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    if (!en) begin
      state_next      = IDLE;
      settle_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end
        SETTLE: begin
          if (chg) begin
            settle_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt + SC_W'(1);
            if (settle_cnt == SETTLE_LAST) state_next = CHECK;
          end
        end
        CHECK: begin
          if (chg) begin
            state_next      = SETTLE;
            settle_cnt_next = '0;
          end
        end
        default: begin
          state_next      = IDLE;
          settle_cnt_next = '0;
        end
      endcase
    end
  end

  // Statistics only move while enabled, so dropping en freezes them.
  always_comb begin
    compare    = 1'b0;
    phase_done = 1'b0;
    if (en && state == CHECK) begin
      compare    = !chg;
      phase_done = chg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mask_1  <= '0;
      err_mask_2  <= '0;
      err_count   <= '0;
      phase_count <= '0;
      led_ok      <= 1'b0;
    end else if (clear) begin
      err_mask_1  <= '0;
      err_mask_2  <= '0;
      err_count   <= '0;
      phase_count <= '0;
      led_ok      <= 1'b0;
    end else begin
      if (compare) begin
        err_mask_1 <= err_mask_1 | diff_1;
        err_mask_2 <= err_mask_2 | diff_2;
        if (mismatch) err_count <= CNT_W'(sat_inc(32'(err_count), unsigned'(CNT_W)));
      end
      if (phase_done) begin
        phase_count <= CNT_W'(sat_inc(32'(phase_count), unsigned'(CNT_W)));
        if (!err_any) led_ok <= ~led_ok;
      end
    end
  end

  assign err_any = (|err_mask_1) || (|err_mask_2);
  assign led_err = err_any;

endmodule

// File: tb/tb_io_loopback_checker.sv
// Self-checking bench for io_loopback_checker: directed table, reset corner case and
// randomized traffic against a cycle-distance reference model.
module tb_io_loopback_checker;
  import io_check_pkg::*;

  localparam int W = 54;
  localparam int S = 8;
  localparam logic [W-1:0] M1F = 54'd1 << 5;
  localparam logic [W-1:0] M2F = 54'd1 << 53;

  logic clk = 1'b0;
  logic rst, en, clear;
  logic [W-1:0] exp_1, exp_2, lb_1, lb_2;

  logic [W-1:0]  mask_1, mask_2, mask4_1, mask4_2;
  logic          any, any4, led_ok, led_ok4, led_err, led_err4;
  logic [15:0]   err_count, phase_count;
  logic [3:0]    err_count4, phase_count4;

  always #5 clk = ~clk;

  io_loopback_checker #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .exp_1(exp_1), .exp_2(exp_2), .lb_1(lb_1), .lb_2(lb_2),
    .err_mask_1(mask_1), .err_mask_2(mask_2), .err_any(any),
    .err_count(err_count), .phase_count(phase_count),
    .led_ok(led_ok), .led_err(led_err)
  );

  io_loopback_checker #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .exp_1(exp_1), .exp_2(exp_2), .lb_1(lb_1), .lb_2(lb_2),
    .err_mask_1(mask4_1), .err_mask_2(mask4_2), .err_any(any4),
    .err_count(err_count4), .phase_count(phase_count4),
    .led_ok(led_ok4), .led_err(led_err4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a cycle is a compare cycle when enabled and at least S cycles
  // have passed since the last restart (enable from idle, or an exp change).
  logic [W-1:0] m_mask1, m_mask2, m_expq1, m_expq2;
  logic [W-1:0] m_lbd1_1, m_lbd1_2, m_lbd2_1, m_lbd2_2;
  int  m_err, m_phase, m_cyc, m_restart;
  bit  m_led, m_active;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    m_mask1 = '0; m_mask2 = '0; m_expq1 = '0; m_expq2 = '0;
    m_lbd1_1 = '0; m_lbd1_2 = '0; m_lbd2_1 = '0; m_lbd2_2 = '0;
    m_err = 0; m_phase = 0; m_cyc = 0; m_restart = 0;
    m_led = 1'b0; m_active = 1'b0;
  endtask

  task automatic model_step();
    bit ch, in_check, cmp, ph;
    logic [W-1:0] d1, d2;
    ch       = (exp_1 !== m_expq1) || (exp_2 !== m_expq2);
    in_check = m_active && ((m_cyc - m_restart) >= S);
    cmp      = en && in_check && !ch;
    ph       = en && in_check && ch;
    d1       = m_lbd2_1 ^ m_expq1;
    d2       = m_lbd2_2 ^ m_expq2;
    if (clear) begin
      m_mask1 = '0; m_mask2 = '0; m_err = 0; m_phase = 0; m_led = 1'b0;
    end else begin
      if (cmp) begin
        m_mask1 = m_mask1 | d1;
        m_mask2 = m_mask2 | d2;
        if ((d1 | d2) != '0) m_err++;
      end
      if (ph) begin
        m_phase++;
        if (m_mask1 == '0 && m_mask2 == '0) m_led = ~m_led;
      end
    end
    if (!en) m_active = 1'b0;
    else begin
      if (!m_active || ch) m_restart = m_cyc;
      m_active = 1'b1;
    end
    m_expq1 = exp_1; m_expq2 = exp_2;
    m_lbd2_1 = m_lbd1_1; m_lbd2_2 = m_lbd1_2;
    m_lbd1_1 = lb_1; m_lbd1_2 = lb_2;
    m_cyc++;
  endtask

  task automatic model_compare();
    bit m_any;
    m_any = (m_mask1 != '0) || (m_mask2 != '0);
    chk("mdl.mask1", mask_1, m_mask1);
    chk("mdl.mask2", mask_2, m_mask2);
    chk("mdl.err_any", any, m_any);
    chk("mdl.led_err", led_err, m_any);
    chk("mdl.led_ok", led_ok, m_led);
    chk("mdl.err_count", err_count, sat(m_err, 16));
    chk("mdl.phase_count", phase_count, sat(m_phase, 16));
    chk("mdl.err_count4", err_count4, sat(m_err, 4));
    chk("mdl.phase_count4", phase_count4, sat(m_phase, 4));
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit sel, input bit fault);
    exp_1 = sel ? '1 : '0;
    exp_2 = ~exp_1;
    lb_1  = fault ? (exp_1 & ~M1F) : exp_1;
    lb_2  = fault ? (exp_2 | M2F) : exp_2;
  endtask

  function automatic logic [W-1:0] rnd54();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  typedef struct {
    string        name;
    bit           en;
    bit           clr;
    bit           sel;
    bit           fault;
    int           ncyc;
    int           phase;
    int           err;
    int           err4;
    bit           led;
    bit           any;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input bit e, input bit c, input bit s, input bit f,
                         input int n, input int ph, input int er, input int er4, input bit ld,
                         input bit an, input logic [W-1:0] m1, input logic [W-1:0] m2);
    vec_t v;
    v.name = name; v.en = e; v.clr = c; v.sel = s; v.fault = f; v.ncyc = n;
    v.phase = ph; v.err = er; v.err4 = er4; v.led = ld; v.any = an; v.m1 = m1; v.m2 = m2;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] f1, f2;
    int hold, off, first;

    //       name        en clr sel flt  n  ph  err e4 led any m1   m2
    add_vec("pre",        0, 0, 1, 0,  4, 0,  0,  0, 0, 0, '0,  '0);
    add_vec("ok_t0",      1, 0, 0, 0, 32, 0,  0,  0, 0, 0, '0,  '0);
    add_vec("ok_t1",      1, 0, 1, 0, 32, 1,  0,  0, 1, 0, '0,  '0);
    add_vec("ok_t2",      1, 0, 0, 0, 32, 2,  0,  0, 0, 0, '0,  '0);
    add_vec("ok_t3",      1, 0, 1, 0,  4, 3,  0,  0, 1, 0, '0,  '0);
    add_vec("clr_a",      0, 1, 1, 1,  2, 0,  0,  0, 0, 0, '0,  '0);
    add_vec("flt_t0",     1, 0, 0, 1, 32, 0,  0,  0, 0, 0, '0,  '0);
    add_vec("flt_t1",     1, 0, 1, 1, 32, 1, 24, 15, 1, 1, M1F, M2F);
    add_vec("flt_t2",     1, 0, 0, 1, 32, 2, 24, 15, 1, 1, M1F, M2F);
    add_vec("flt_t3",     1, 0, 1, 1,  4, 3, 24, 15, 1, 1, M1F, M2F);
    add_vec("accum",      1, 0, 1, 1, 10, 3, 30, 15, 1, 1, M1F, M2F);
    add_vec("clr_pulse",  1, 1, 1, 1,  1, 0,  0,  0, 0, 0, '0,  '0);
    add_vec("re_record",  1, 0, 1, 1,  1, 0,  1,  1, 0, 1, M1F, M2F);
    add_vec("clr_b",      0, 1, 1, 1,  2, 0,  0,  0, 0, 0, '0,  '0);
    for (int i = 0; i < 6; i++)
      add_vec($sformatf("fast%0d", i), 1, 0, i[0], 1, 5, 0, 0, 0, 0, 0, '0, '0);
    add_vec("settled",    1, 0, 1, 1, 12, 0,  9,  9, 0, 1, M1F, M2F);

    rst = 1'b1; en = 1'b0; clear = 1'b0;
    exp_1 = '0; exp_2 = '0; lb_1 = '0; lb_2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_compare();
    model_step();
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      en = vecs[i].en;
      clear = vecs[i].clr;
      apply(vecs[i].sel, vecs[i].fault);
      repeat (vecs[i].ncyc) tick();
      chk({vecs[i].name, ".phase"}, phase_count, vecs[i].phase);
      chk({vecs[i].name, ".err"}, err_count, vecs[i].err);
      chk({vecs[i].name, ".err4"}, err_count4, vecs[i].err4);
      chk({vecs[i].name, ".led_ok"}, led_ok, vecs[i].led);
      chk({vecs[i].name, ".led_err"}, led_err, vecs[i].any);
      chk({vecs[i].name, ".mask1"}, mask_1, vecs[i].m1);
      chk({vecs[i].name, ".mask2"}, mask_2, vecs[i].m2);
    end

    // Reset while checking with errors latched.
    #2;
    rst = 1'b1;
    #1;
    chk("rst.mask1", mask_1, '0);
    chk("rst.mask2", mask_2, '0);
    chk("rst.led_err", led_err, 0);
    chk("rst.err_count", err_count, 0);
    chk("rst.phase_count", phase_count, 0);
    chk("rst.led_ok", led_ok, 0);
    chk("rst.state", 64'(dut.state), 64'(IDLE));
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_compare();
    model_step();
    @(posedge clk);
    #1;
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      @(negedge clk);
      if (err_count != 0) first = k;
      model_compare();
      model_step();
      @(posedge clk);
      #1;
    end
    chk("rst.first_err_cycle", 64'(first), 64'(S + 1));

    // Randomized traffic against the model.
    hold = 0; off = 0; f1 = '0; f2 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 40);
        exp_1 = rnd54();
        exp_2 = rnd54();
        case ($urandom_range(0, 3))
          2: begin
            f1 = 54'd1 << $urandom_range(0, W - 1);
            f2 = '0;
          end
          3: begin
            f1 = rnd54() & rnd54() & rnd54();
            f2 = rnd54() & rnd54() & rnd54();
          end
          default: begin
            f1 = '0;
            f2 = '0;
          end
        endcase
      end
      hold--;
      if (off > 0) begin
        off--;
        en = (off == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        off = $urandom_range(1, 6);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
      clear = ($urandom_range(0, 99) == 0);
      lb_1 = exp_1 ^ f1;
      lb_2 = exp_2 ^ f2;
      if ($urandom_range(0, 29) == 0) lb_2 = lb_2 ^ (54'd1 << $urandom_range(0, W - 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
